sound_tone_gen: RTL and testbench



---
 rtl/sound_pkg.sv | 32 +++
 rtl/sound_half_period_div.sv | 34 +++
 rtl/sound_tone_gen.sv | 147 ++++++++++++++
 tb/tb_sound_tone_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// sound_pkg: shared sound codes, sequencer state enum and default timing values
package sound_pkg;

    // Sound codes, shared with the downstream sound_controller
    localparam logic [1:0] CODE_PING = 2'b00;
    localparam logic [1:0] CODE_PONG = 2'b01;
    localparam logic [1:0] CODE_GO   = 2'b10;
    localparam logic [1:0] CODE_STOP = 2'b11;

    // Width of the half-period divider counter
    localparam int DIV_W = 16;

    // Default timing for a 12 MHz clock
    localparam int DEF_TICK_DIV   = 12000;
    localparam int DEF_NOTE_TICKS = 50;
    localparam int DEF_DIV_PING   = 6000;
    localparam int DEF_DIV_PONG   = 12000;
    localparam int DEF_DIV_LO     = 24000;
    localparam int DEF_DIV_HI     = 3000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        NOTE_A = 2'd1,
        NOTE_B = 2'd2
    } state_t;

    // go/stop are two-note chirps; ping/pong are single long notes
    function automatic logic is_chirp(input logic [1:0] c);
        return c[1];
    endfunction

endpackage

// File: rtl/sound_half_period_div.sv
// sound_half_period_div: loadable 16-bit half-period divider with clear and toggle strobe
//
// Ports:
//   clk   system clock
//   rstn  asynchronous active-low reset
//   clr   restart the count from 0 at the next edge (overrides en)
//   en    count enable
//   div   half-period length in clk cycles (>= 1), may change on the fly
//   tog   strobe in the last cycle of each half-period
module sound_half_period_div
    import sound_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tog
);

    logic [DIV_W-1:0] cnt;

    assign tog = en && !clr && cnt == div - 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tog ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/sound_tone_gen.sv
// sound_tone_gen: turns a play strobe plus sound code into a timed square-wave tone
//
// Ports:
//   clk    system clock
//   rstn   asynchronous active-low reset
//   play   one-cycle request strobe
//   code   sound code sampled with play (00 ping, 01 pong, 10 go, 11 stop)
//   mute   silences sound from the next edge; sequencing continues
//   sound  registered square-wave tone
//   busy   high while a sound is sequencing
//   done   one-cycle pulse when a sound completes naturally
//
// Build option SOUND_QUEUE_EN: play while busy is held in a one-entry
// pending buffer and started after the current sound finishes, instead of
// aborting the current sound.
module sound_tone_gen
    import sound_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int NOTE_TICKS = DEF_NOTE_TICKS,
    parameter int DIV_PING   = DEF_DIV_PING,
    parameter int DIV_PONG   = DEF_DIV_PONG,
    parameter int DIV_LO     = DEF_DIV_LO,
    parameter int DIV_HI     = DEF_DIV_HI
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       play,
    input  logic [1:0] code,
    input  logic       mute,
    output logic       sound,
    output logic       busy,
    output logic       done
);

    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int NW = $clog2(2 * NOTE_TICKS);
    localparam logic [TW-1:0] TICK_M1  = TW'(TICK_DIV - 1);
    localparam logic [NW-1:0] LONG_M1  = NW'(2 * NOTE_TICKS - 1);
    localparam logic [NW-1:0] SHORT_M1 = NW'(NOTE_TICKS - 1);

    state_t           state, state_n;
    logic [1:0]       code_q, start_code, eff_code;
    logic [TW-1:0]    tick_cnt;
    logic [NW-1:0]    note_cnt;
    logic [DIV_W-1:0] div_sel;
    logic             idle, start, chirp, tick_wrap, note_end, last, tog;
    logic             phase, phase_n, done_q;

    assign idle  = state == IDLE;
    assign chirp = is_chirp(code_q);

`ifdef SOUND_QUEUE_EN
    logic       pend_v;
    logic [1:0] pend_c;

    // A new sound only starts from IDLE; a direct play beats the pending one
    assign start      = idle && (play || pend_v);
    assign start_code = play ? code : pend_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_v <= 1'b0;
            pend_c <= CODE_PING;
        end else if (start) begin
            pend_v <= 1'b0;
        end else if (play) begin
            pend_v <= 1'b1;
            pend_c <= code;
        end
    end
`else
    // Any play, busy or not, (re)starts the sequence
    assign start      = play;
    assign start_code = code;
`endif

    assign tick_wrap = !idle && tick_cnt == TICK_M1;
    assign note_end  = tick_wrap && note_cnt == ((state == NOTE_A && !chirp) ? LONG_M1 : SHORT_M1);
    assign last      = note_end && (state == NOTE_B || !chirp);

    // The second chirp note swaps go/stop, which swaps the LO/HI divider
    assign eff_code = state == NOTE_B ? {code_q[1], ~code_q[0]} : code_q;

    always_comb begin
        div_sel = eff_code == CODE_PING ? DIV_W'(DIV_PING) :
                  eff_code == CODE_PONG ? DIV_W'(DIV_PONG) :
                  eff_code == CODE_GO   ? DIV_W'(DIV_LO)   : DIV_W'(DIV_HI);
    end

    sound_half_period_div u_div (
        .clk  (clk),
        .rstn (rstn),
        .clr  (start || note_end),
        .en   (!idle),
        .div  (div_sel),
        .tog  (tog)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = start                                  ? NOTE_A :
                  (note_end && state == NOTE_A && chirp) ? NOTE_B :
                  last                                   ? IDLE   : state;
    end

    // Every note starts on the high phase; finishing drops it low
    always_comb begin
        phase_n = start || (note_end && !last) ? 1'b1 :
                  last                         ? 1'b0 :
                  tog                          ? ~phase : phase;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            code_q   <= CODE_PING;
            tick_cnt <= '0;
            note_cnt <= '0;
            phase    <= 1'b0;
            sound    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            code_q   <= start ? start_code : code_q;
            tick_cnt <= (start || note_end || idle || tick_wrap) ? '0 : tick_cnt + 1'b1;
            note_cnt <= (start || note_end || idle) ? '0 : tick_wrap ? note_cnt + 1'b1 : note_cnt;
            phase    <= phase_n;
            sound    <= phase_n && !mute && state_n != IDLE;
            done_q   <= last && !start;
        end
    end

    always_comb begin
`ifdef SOUND_QUEUE_EN
        busy = !idle || pend_v;
`else
        busy = !idle;
`endif
        done = done_q;
    end

endmodule

// File: tb/tb_sound_tone_gen.sv
// tb_sound_tone_gen: directed tests of sound_tone_gen against a cycle-count model
module tb_sound_tone_gen;

    localparam int TICK_DIV   = 10;
    localparam int NOTE_TICKS = 2;
    localparam int NOTE_CYC   = TICK_DIV * NOTE_TICKS;
    localparam int TOTAL_CYC  = 2 * NOTE_CYC;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       play = 1'b0;
    logic [1:0] code = 2'b00;
    logic       mute = 1'b0;
    logic       sound, busy, done;

    int checks = 0;
    int passed = 0;
    int now = 0;
    bit chk_en = 1'b0;

    sound_tone_gen #(
        .TICK_DIV   (TICK_DIV),
        .NOTE_TICKS (NOTE_TICKS),
        .DIV_PING   (3),
        .DIV_PONG   (5),
        .DIV_LO     (4),
        .DIV_HI     (2)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .play  (play),
        .code  (code),
        .mute  (mute),
        .sound (sound),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s at t=%0t: got %b, expected %b", nm, $time, act, exp);
    endtask

    // Half-period of the tone t cycles (1-based) into a sound of the given code
    function automatic int half_period(input logic [1:0] c, input int t);
        case (c)
            2'b00: return 3;
            2'b01: return 5;
            2'b10: return t > NOTE_CYC ? 2 : 4;
            default: return t > NOTE_CYC ? 4 : 2;
        endcase
    endfunction

    function automatic logic tone_high(input logic [1:0] c, input int t);
        int k;
        k = (c[1] && t > NOTE_CYC) ? t - NOTE_CYC : t;
        return ((k - 1) / half_period(c, t)) % 2 == 0;
    endfunction

    // Model: a sound is just a code plus the number of cycles since it started
    logic       m_act = 1'b0, m_done = 1'b0, m_mute = 1'b0, m_pend = 1'b0;
    logic [1:0] m_code = 2'b00, m_pc = 2'b00;
    int         m_t = 0;

    always @(posedge clk or negedge rstn) begin
        logic was;
        if (!rstn) begin
            m_act = 1'b0; m_done = 1'b0; m_mute = 1'b0; m_pend = 1'b0; m_t = 0;
        end else begin
            was = m_act;
            m_done = 1'b0;
            m_mute = mute;
`ifdef SOUND_QUEUE_EN
            if (!was && (play || m_pend)) begin
                m_code = play ? code : m_pc; m_act = 1'b1; m_t = 1; m_pend = 1'b0;
            end else begin
                if (was) begin
                    m_t++;
                    if (m_t > TOTAL_CYC) begin m_act = 1'b0; m_done = 1'b1; end
                end
                if (play) begin m_pend = 1'b1; m_pc = code; end
            end
`else
            if (play) begin
                m_code = code; m_act = 1'b1; m_t = 1;
            end else if (was) begin
                m_t++;
                if (m_t > TOTAL_CYC) begin m_act = 1'b0; m_done = 1'b1; end
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_sound", sound, m_act && !m_mute && tone_high(m_code, m_t));
            chk("model_busy", busy, m_act || m_pend);
            chk("model_done", done, m_done);
        end
    end

    // Advance to cycle n of the current scenario, 6 time units after its edge
    task automatic go_to(input int n);
        repeat (n - now) @(posedge clk);
        #6;
        now = n;
    endtask

    task automatic start_sound(input logic [1:0] c);
        now = 0;
        play = 1'b1;
        code = c;
        go_to(1);
        play = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #6;
        chk("rst_sound", sound, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rstn = 1'b1;
        chk_en = 1'b1;
        go_to(2);

        // ping: 40 busy cycles, toggling every 3
        start_sound(2'b00);
        chk("ping_c1_sound", sound, 1'b1);
        chk("ping_c1_busy", busy, 1'b1);
        go_to(3);  chk("ping_c3_sound", sound, 1'b1);
        go_to(4);  chk("ping_c4_sound", sound, 1'b0);
        go_to(7);  chk("ping_c7_sound", sound, 1'b1);
        go_to(40); chk("ping_c40_busy", busy, 1'b1);
        go_to(41);
        chk("ping_c41_done", done, 1'b1);
        chk("ping_c41_busy", busy, 1'b0);
        chk("ping_c41_sound", sound, 1'b0);
        go_to(42); chk("ping_c42_done", done, 1'b0);
        go_to(45);

        // go: low note then high note, phase restarting high at the switch
        start_sound(2'b10);
        go_to(4);  chk("go_c4_sound", sound, 1'b1);
        go_to(5);  chk("go_c5_sound", sound, 1'b0);
        go_to(20); chk("go_c20_sound", sound, 1'b1);
        go_to(21); chk("go_c21_sound", sound, 1'b1);
        go_to(23); chk("go_c23_sound", sound, 1'b0);
        go_to(40); chk("go_c40_done", done, 1'b0);
        go_to(41); chk("go_c41_done", done, 1'b1);
        go_to(45);

        // mute during cycles 10-19 of a pong
        start_sound(2'b01);
        go_to(10); mute = 1'b1;
        go_to(11); chk("mute_c11_sound", sound, 1'b0);
        go_to(20); chk("mute_c20_sound", sound, 1'b0); mute = 1'b0;
        go_to(21); chk("mute_c21_sound", sound, 1'b1);
        go_to(41); chk("mute_c41_done", done, 1'b1);
        go_to(45);

        // reset in the middle of a go, then a cold ping
        start_sound(2'b10);
        go_to(12);
        rstn = 1'b0;
        #1;
        chk("arst_sound", sound, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        go_to(13); rstn = 1'b1;
        go_to(16);
        start_sound(2'b00);
        chk("cold_c1_sound", sound, 1'b1);
        go_to(41); chk("cold_c41_done", done, 1'b1);
        go_to(45);

`ifdef SOUND_QUEUE_EN
        // queued pong after a ping
        start_sound(2'b00);
        go_to(5);  play = 1'b1; code = 2'b01;
        go_to(6);  play = 1'b0;
        go_to(41); chk("q_c41_done", done, 1'b1); chk("q_c41_busy", busy, 1'b1);
        go_to(42); chk("q_c42_sound", sound, 1'b1); chk("q_c42_done", done, 1'b0);
        go_to(81); chk("q_c81_busy", busy, 1'b1);
        go_to(82); chk("q_c82_done", done, 1'b1); chk("q_c82_busy", busy, 1'b0);
        go_to(86);
`else
        // retrigger: stop aborts a ping, single done at 56
        start_sound(2'b00);
        go_to(15); play = 1'b1; code = 2'b11;
        go_to(16); play = 1'b0;
        chk("rt_c16_sound", sound, 1'b1);
        go_to(17); chk("rt_c17_sound", sound, 1'b1);
        go_to(18); chk("rt_c18_sound", sound, 1'b0);
        go_to(41); chk("rt_c41_done", done, 1'b0);
        go_to(56); chk("rt_c56_done", done, 1'b1);
        go_to(60);

        // play coinciding with natural completion restarts without done
        start_sound(2'b00);
        go_to(40); play = 1'b1; code = 2'b00;
        go_to(41); play = 1'b0;
        chk("sim_c41_done", done, 1'b0);
        chk("sim_c41_busy", busy, 1'b1);
        chk("sim_c41_sound", sound, 1'b1);
        go_to(81); chk("sim_c81_done", done, 1'b1);
        go_to(85);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
